// File: rtl/spi_pkg.sv
// SPI master shared types and constants.
// FSM state encoding and transfer sizing.
package spi_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    TRANSFER,
    HOLD,
    FINISH
  } state_e;

  localparam int BITS_PER_XFER = 8;
  localparam int DIV_W = 8;
  localparam int EDGE_W = $clog2(2 * BITS_PER_XFER);
  localparam logic [EDGE_W-1:0] LAST_EDGE =
    EDGE_W'(2 * BITS_PER_XFER - 1);

endpackage

// File: rtl/spi_clk_gen.sv
// SCLK half-period counter for the SPI master.
// Emits a one-cycle tick at the end of each half-period.
module spi_clk_gen
  import spi_pkg::*;
#(
  parameter int unsigned DIV_HALF = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en,
  input  logic reload,
  output logic tick
);

  localparam logic [DIV_W-1:0] LAST = DIV_W'(DIV_HALF - 1);

  logic [DIV_W-1:0] cnt_q;
  logic [DIV_W-1:0] cnt_d;

  // Wrap at LAST; restart from zero on every state entry or when idle.
  always_comb begin
    tick  = en && (cnt_q == LAST);
    cnt_d = cnt_q + 1'b1;
    if (!en || reload || tick) begin
      cnt_d = '0;
    end
  end

  // Counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master, LSB first, one byte per transfer.
// Optional one-entry TX holding buffer: SPI_TX_BUFFER_EN.
module spi_master_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DIV_HALF = 2
) (
  input  logic       CLK,
  input  logic       CLR_N,
  input  logic       START,
  input  logic       ABORT,
  input  logic [7:0] TX_DATA,
  input  logic       MISO,
  output logic       SCLK,
  output logic       MOSI,
  output logic       CS_N,
  output logic [7:0] RX_DATA,
  output logic       BUSY,
  output logic       DONE,
  output logic       BUF_FULL
);

  state_e state_q, state_d;
  logic sclk_q, sclk_d;
  logic cs_n_q, cs_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic [7:0] rx_q, rx_d;
  logic [7:0] tx_sh_q, tx_sh_d;
  logic [7:0] rx_sh_q, rx_sh_d;
  logic [EDGE_W-1:0] edge_q, edge_d;
  logic tick;
  logic reload;
  logic abort_hit;
`ifdef SPI_TX_BUFFER_EN
  logic [7:0] buf_q, buf_d;
  logic buf_full_q, buf_full_d;
`endif

  spi_clk_gen #(
    .DIV_HALF(DIV_HALF)
  ) u_clk_gen (
    .clk   (CLK),
    .rst_n (CLR_N),
    .en    (busy_q),
    .reload(reload),
    .tick  (tick)
  );

  assign abort_hit = ABORT &&
    (state_q inside {SETUP, TRANSFER, HOLD});

  // Next-state and datapath decode.
  always_comb begin
    state_d = state_q;
    sclk_d  = sclk_q;
    cs_n_d  = cs_n_q;
    done_d  = 1'b0;
    rx_d    = rx_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    edge_d  = edge_q;
`ifdef SPI_TX_BUFFER_EN
    buf_d      = buf_q;
    buf_full_d = buf_full_q;
    if (START && busy_q && !buf_full_q &&
        state_q != FINISH) begin
      buf_d      = TX_DATA;
      buf_full_d = 1'b1;
    end
`endif
    if (abort_hit) begin
      state_d = IDLE;
      sclk_d  = 1'b0;
      cs_n_d  = 1'b1;
      tx_sh_d = '0;
`ifdef SPI_TX_BUFFER_EN
      buf_full_d = 1'b0;
`endif
    end else begin
      unique case (state_q)
        IDLE: begin
          if (START) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            tx_sh_d = TX_DATA;
            rx_sh_d = '0;
            edge_d  = '0;
          end
        end
        SETUP: begin
          if (tick) begin
            state_d = TRANSFER;
            edge_d  = '0;
          end
        end
        TRANSFER: begin
          if (tick) begin
            sclk_d = ~sclk_q;
            edge_d = edge_q + 1'b1;
            if (!edge_q[0]) begin
              rx_sh_d = {MISO, rx_sh_q[7:1]};
            end else if (edge_q != LAST_EDGE) begin
              tx_sh_d = {1'b0, tx_sh_q[7:1]};
            end
            if (edge_q == LAST_EDGE) begin
              state_d = HOLD;
            end
          end
        end
        HOLD: begin
          if (tick) begin
            state_d = FINISH;
            done_d  = 1'b1;
            rx_d    = rx_sh_q;
`ifdef SPI_TX_BUFFER_EN
            cs_n_d  = ~buf_full_d;
`else
            cs_n_d  = 1'b1;
`endif
          end
        end
        FINISH: begin
          state_d = IDLE;
`ifdef SPI_TX_BUFFER_EN
          if (buf_full_q) begin
            state_d    = SETUP;
            cs_n_d     = 1'b0;
            tx_sh_d    = buf_q;
            buf_full_d = 1'b0;
            rx_sh_d    = '0;
            edge_d     = '0;
          end else if (START) begin
            state_d = SETUP;
            cs_n_d  = 1'b0;
            tx_sh_d = TX_DATA;
            rx_sh_d = '0;
            edge_d  = '0;
          end
`endif
        end
      endcase
    end
    busy_d = (state_d != IDLE);
    reload = (state_d != state_q);
  end

  // FSM and registered outputs.
  always_ff @(posedge CLK or negedge CLR_N) begin
    if (!CLR_N) begin
      state_q <= IDLE;
      sclk_q  <= 1'b0;
      cs_n_q  <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rx_q    <= '0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      edge_q  <= '0;
`ifdef SPI_TX_BUFFER_EN
      buf_q      <= '0;
      buf_full_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sclk_q  <= sclk_d;
      cs_n_q  <= cs_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rx_q    <= rx_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      edge_q  <= edge_d;
`ifdef SPI_TX_BUFFER_EN
      buf_q      <= buf_d;
      buf_full_q <= buf_full_d;
`endif
    end
  end

  assign SCLK    = sclk_q;
  assign MOSI    = tx_sh_q[0];
  assign CS_N    = cs_n_q;
  assign RX_DATA = rx_q;
  assign BUSY    = busy_q;
  assign DONE    = done_q;
`ifdef SPI_TX_BUFFER_EN
  assign BUF_FULL = buf_full_q;
`else
  assign BUF_FULL = 1'b0;
`endif

endmodule
